// File: rtl/multi_stage_pipeline_reg_pkg.sv
// Shared types and helpers for the multi-stage valid/ready register pipeline.
package multi_stage_pipeline_reg_pkg;

    // Occupancy of one skid stage: nothing held, main register held, main and skid held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Width needed to count 0 .. 2*depth words.
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/multi_stage_pipeline_reg_checker.sv
// Protocol checks on the pipeline's downstream side and occupancy range.
module multi_stage_pipeline_reg_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 3
) (
    input logic                  clk,
    input logic                  reset,
    input logic                  flush,
    input logic                  out_valid,
    input logic                  out_ready,
    input logic [DATA_WIDTH-1:0] out_data,
    input logic [CNT_W-1:0]      occupancy
);

    // A stalled output word must stay put until it is taken (flush excepted).
    a_out_hold: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

    // The counter can never exceed the storage capacity.
    a_occ_range: assert property (@(posedge clk) disable iff (reset)
        occupancy <= CNT_W'(2 * DEPTH));

endmodule

// File: rtl/multi_stage_pipeline_reg_skid_stage.sv
// One skid-buffer stage: a main register drives the downstream side and a skid
// register catches the word that arrives while the registered ready is still high.
// No combinational path exists from dn_ready_i to up_ready_o.
module multi_stage_pipeline_reg_skid_stage
    import multi_stage_pipeline_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] up_data_i,
    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    output logic [DATA_WIDTH-1:0] dn_data_o,
    output logic                  dn_valid_o,
    input  logic                  dn_ready_i
);

    stage_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  valid_q, valid_d;
    logic                  up_ready_q, up_ready_d;
    logic                  up_fire_s;
    logic                  dn_fire_s;

    assign up_fire_s  = up_valid_i & up_ready_q;
    assign dn_fire_s  = valid_q & dn_ready_i;
    assign up_ready_o = up_ready_q;
    assign dn_valid_o = valid_q;
    assign dn_data_o  = main_q;

    // State and datapath registers; reset clears everything including data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            main_q     <= {DATA_WIDTH{1'b0}};
            skid_q     <= {DATA_WIDTH{1'b0}};
            valid_q    <= 1'b0;
            up_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            valid_q    <= valid_d;
            up_ready_q <= up_ready_d;
        end
    end

    // Next-state: flush empties the stage and overrides any transfer.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (up_fire_s) state_d = BUSY;
                    else           state_d = EMPTY;
                end
                BUSY: begin
                    if (up_fire_s && !dn_fire_s)      state_d = FULL;
                    else if (!up_fire_s && dn_fire_s) state_d = EMPTY;
                    else                              state_d = BUSY;
                end
                FULL: begin
                    if (dn_fire_s) state_d = BUSY;
                    else           state_d = FULL;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Datapath moves and registered handshake outputs derived from the next state.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d = main_q;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (up_fire_s) main_d = up_data_i;
                    else           main_d = main_q;
                end
                BUSY: begin
                    if (up_fire_s && dn_fire_s) main_d = up_data_i;
                    else if (up_fire_s)         skid_d = up_data_i;
                    else                        main_d = main_q;
                end
                FULL: begin
                    if (dn_fire_s) main_d = skid_q;
                    else           main_d = main_q;
                end
                default: main_d = main_q;
            endcase
        end
        valid_d    = (state_d != EMPTY);
        up_ready_d = (!flush) && (state_d != FULL);
    end

endmodule

// File: rtl/multi_stage_pipeline_reg.sv
// DEPTH skid stages chained into a fully registered valid/ready pipeline with a
// synchronous flush and an occupancy counter.
module multi_stage_pipeline_reg
    import multi_stage_pipeline_reg_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 2,
    localparam int CNT_W      = occ_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic                  input_valid,
    output logic                  input_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      occupancy
);

    // Element i is the input side of stage i; element DEPTH is the block output.
    logic [DEPTH:0][DATA_WIDTH-1:0] chain_data_s;
    logic [DEPTH:0]                 chain_valid_s;
    logic [DEPTH:0]                 chain_ready_s;

    logic [CNT_W-1:0] count_q, count_d;
    logic             in_fire_s;
    logic             out_fire_s;

    assign chain_data_s[0]      = input_data;
    assign chain_valid_s[0]     = input_valid;
    assign chain_ready_s[DEPTH] = out_ready;

    assign input_ready = chain_ready_s[0];
    assign out_data    = chain_data_s[DEPTH];
    assign out_valid   = chain_valid_s[DEPTH];
    assign occupancy   = count_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        multi_stage_pipeline_reg_skid_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .up_data_i  (chain_data_s[g]),
            .up_valid_i (chain_valid_s[g]),
            .up_ready_o (chain_ready_s[g]),
            .dn_data_o  (chain_data_s[g+1]),
            .dn_valid_o (chain_valid_s[g+1]),
            .dn_ready_i (chain_ready_s[g+1])
        );
    end

    // A word offered during flush is discarded, so it is not counted.
    assign in_fire_s  = input_valid & input_ready & ~flush;
    assign out_fire_s = out_valid & out_ready;

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Occupancy update: flush empties, otherwise net of accepted and delivered words.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = {CNT_W{1'b0}};
        end else begin
            case ({in_fire_s, out_fire_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    multi_stage_pipeline_reg_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) u_checker (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (count_q)
    );

endmodule

// File: tb/tb_multi_stage_pipeline_reg.sv
// Bench: directed vector table on a DEPTH=2 instance, hand-written flush and
// latency sequences, and randomized traffic on DEPTH=1 and DEPTH=3 instances
// scored against a queue model.
module tb_multi_stage_pipeline_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // DEPTH=2 directed instance
    logic       d_reset, d_flush, d_iv, d_ir, d_ov, d_or;
    logic [7:0] d_id, d_od;
    logic [2:0] d_occ;

    // Random instances share their inputs
    logic       r_reset, r_flush, r_iv, r_or;
    logic [7:0] r_id;
    logic       r1_ir, r1_ov, r3_ir, r3_ov;
    logic [7:0] r1_od, r3_od;
    logic [1:0] r1_occ;
    logic [2:0] r3_occ;

    multi_stage_pipeline_reg #(.DATA_WIDTH(8), .DEPTH(2)) dut2 (
        .clk(clk), .reset(d_reset), .flush(d_flush),
        .input_data(d_id), .input_valid(d_iv), .input_ready(d_ir),
        .out_data(d_od), .out_valid(d_ov), .out_ready(d_or), .occupancy(d_occ));

    multi_stage_pipeline_reg #(.DATA_WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .reset(r_reset), .flush(r_flush),
        .input_data(r_id), .input_valid(r_iv), .input_ready(r1_ir),
        .out_data(r1_od), .out_valid(r1_ov), .out_ready(r_or), .occupancy(r1_occ));

    multi_stage_pipeline_reg #(.DATA_WIDTH(8), .DEPTH(3)) dut3 (
        .clk(clk), .reset(r_reset), .flush(r_flush),
        .input_data(r_id), .input_valid(r_iv), .input_ready(r3_ir),
        .out_data(r3_od), .out_valid(r3_ov), .out_ready(r_or), .occupancy(r3_occ));

    typedef struct {
        logic       rst;
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic       chk_d;
        logic [7:0] e_od;
        logic [2:0] e_occ;
    } vec_t;

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic [7:0] id, logic ordy,
                                logic e_ir, logic e_ov, logic chk_d, logic [7:0] e_od,
                                logic [2:0] e_occ);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.chk_d = chk_d; v.e_od = e_od; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one random instance against its model snapshot.
    task automatic chk_model(input string nm, input logic ov, input logic [7:0] od,
                             input int occ, input int qsize, input logic [7:0] qhead,
                             input logic was_stall, input logic [7:0] stall_od);
        check({nm, "_occ"}, occ, qsize);
        if (ov) begin
            check({nm, "_nonempty"}, (qsize > 0) ? 1 : 0, 1);
            check({nm, "_order"}, od, qhead);
        end else begin
            check({nm, "_valid_when_idle"}, ((qsize > 0) && was_stall) ? 1 : 0, 0);
        end
        if (was_stall) begin
            check({nm, "_hold_valid"}, ov, 1);
            check({nm, "_hold_data"}, od, stall_od);
        end
    endtask

    vec_t tbl [17];
    logic [7:0] q1 [$];
    logic [7:0] q3 [$];

    initial begin
        int acc1, acc3;
        logic st1, st3;
        logic [7:0] sd1, sd3;

        d_reset = 1'b1; d_flush = 1'b0; d_iv = 1'b0; d_id = 8'h00; d_or = 1'b0;
        r_reset = 1'b1; r_flush = 1'b0; r_iv = 1'b0; r_id = 8'h00; r_or = 1'b0;

        //            rst   fl    iv    id     or  | ir    ov    chk   od     occ
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0);
        tbl[4]  = mk(1'b0, 1'b0, 1'b1, 8'h15, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 3'd1);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8'h15, 3'd2);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 3'd1);
        tbl[7]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd1);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 3'd2);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 3'd3);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4);
        tbl[12] = mk(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 3'd3);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 3'd2);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 3'd1);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);

        #2;
        // Reset, back-to-back latency, stall fill and drain on DEPTH=2
        for (int i = 0; i < 17; i++) begin
            d_reset = tbl[i].rst; d_flush = tbl[i].fl; d_iv = tbl[i].iv;
            d_id = tbl[i].id; d_or = tbl[i].ordy;
            tick();
            check($sformatf("vec%0d_input_ready", i), d_ir, tbl[i].e_ir);
            check($sformatf("vec%0d_out_valid", i), d_ov, tbl[i].e_ov);
            check($sformatf("vec%0d_occupancy", i), d_occ, tbl[i].e_occ);
            if (tbl[i].chk_d) check($sformatf("vec%0d_out_data", i), d_od, tbl[i].e_od);
        end

        // Flush with three words held and 0xAA offered in the flush cycle
        d_or = 1'b0; d_iv = 1'b1;
        d_id = 8'h11; tick();
        d_id = 8'h22; tick();
        d_id = 8'h33; tick();
        check("flush_pre_occ", d_occ, 3);
        check("flush_pre_ready", d_ir, 1);
        d_flush = 1'b1; d_id = 8'hAA; tick();
        check("flush_out_valid", d_ov, 0);
        check("flush_occ", d_occ, 0);
        check("flush_ready_low", d_ir, 0);
        d_flush = 1'b0; d_or = 1'b1; tick();
        check("flush_ready_back", d_ir, 1);
        check("flush_occ_after", d_occ, 0);
        d_iv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("flush_aa_never_out", d_ov, 0);
        end
        d_iv = 1'b1; d_id = 8'h5A; tick();
        d_iv = 1'b0;
        check("lat2_edge_n", d_ov, 0);
        tick();
        check("lat2_edge_n1_valid", d_ov, 1);
        check("lat2_edge_n1_data", d_od, 8'h5A);
        tick();
        check("lat2_drained", d_occ, 0);

        // DEPTH=1 and DEPTH=3 latency
        for (int i = 0; i < 3; i++) tick();
        r_reset = 1'b0; tick();
        check("r1_ready_after_reset", r1_ir, 1);
        check("r3_ready_after_reset", r3_ir, 1);
        r_iv = 1'b1; r_id = 8'h77; r_or = 1'b1; tick();
        r_iv = 1'b0;
        check("lat1_valid", r1_ov, 1);
        check("lat1_data", r1_od, 8'h77);
        check("lat3_n", r3_ov, 0);
        tick();
        check("lat3_n1", r3_ov, 0);
        tick();
        check("lat3_n2_valid", r3_ov, 1);
        check("lat3_n2_data", r3_od, 8'h77);
        tick();
        check("lat_r1_empty", r1_occ, 0);
        check("lat_r3_empty", r3_occ, 0);

        // Capacity under stall: 2*DEPTH words then ready drops
        acc1 = 0; acc3 = 0;
        r_or = 1'b0; r_iv = 1'b1; r_id = 8'h42;
        for (int i = 0; i < 20; i++) begin
            if (r1_ir) acc1++;
            if (r3_ir) acc3++;
            tick();
        end
        check("cap1_accepted", acc1, 2);
        check("cap3_accepted", acc3, 6);
        check("cap1_occ", r1_occ, 2);
        check("cap3_occ", r3_occ, 6);
        check("cap1_ready", r1_ir, 0);
        check("cap3_ready", r3_ir, 0);
        r_flush = 1'b1; r_iv = 1'b0; tick();
        r_flush = 1'b0;
        check("rflush_occ1", r1_occ, 0);
        check("rflush_occ3", r3_occ, 0);
        check("rflush_ov3", r3_ov, 0);
        check("rflush_ir3", r3_ir, 0);

        // Random traffic against queue models; last cycles drain
        acc1 = 0; acc3 = 0; st1 = 1'b0; st3 = 1'b0; sd1 = 8'h00; sd3 = 8'h00;
        for (int cyc = 0; cyc < 10040; cyc++) begin
            chk_model("rnd1", r1_ov, r1_od, int'(r1_occ), q1.size(),
                      (q1.size() > 0) ? q1[0] : 8'h00, st1, sd1);
            chk_model("rnd3", r3_ov, r3_od, int'(r3_occ), q3.size(),
                      (q3.size() > 0) ? q3[0] : 8'h00, st3, sd3);
            if (cyc < 10000) begin
                r_iv    = ($urandom_range(0, 99) < 70);
                r_or    = ($urandom_range(0, 99) < 60);
                r_flush = ($urandom_range(0, 499) == 0);
                r_id    = 8'($urandom);
            end else begin
                r_iv = 1'b0; r_or = 1'b1; r_flush = 1'b0;
            end
            st1 = r1_ov & ~r_or & ~r_flush; sd1 = r1_od;
            st3 = r3_ov & ~r_or & ~r_flush; sd3 = r3_od;
            if (r1_ov && r_or && q1.size() > 0) void'(q1.pop_front());
            if (r3_ov && r_or && q3.size() > 0) void'(q3.pop_front());
            if (r_flush) begin
                q1.delete();
                q3.delete();
            end else begin
                if (r_iv && r1_ir) begin q1.push_back(r_id); acc1++; end
                if (r_iv && r3_ir) begin q3.push_back(r_id); acc3++; end
            end
            tick();
        end
        check("rnd1_drained", r1_occ, 0);
        check("rnd3_drained", r3_occ, 0);
        check("rnd1_model_empty", q1.size(), 0);
        check("rnd3_model_empty", q3.size(), 0);
        check("rnd1_throughput", (acc1 > 2000) ? 1 : 0, 1);
        check("rnd3_throughput", (acc3 > 2000) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
